// File: rtl/bpu_pkg.sv
// Shared types for the branch predictor: 2-bit saturating counter encoding and its update rule.
package bpu_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  function automatic ctr_t ctr_next(input ctr_t cur, input logic taken);
    ctr_t nxt;
    nxt = cur;
    if (taken && cur != CTR_ST)       nxt = cur + 2'd1;
    else if (!taken && cur != CTR_SNT) nxt = cur - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/bpu_sat_ctr.sv
// 2-bit saturating counter step used on the BTB training path.
module bpu_sat_ctr
  import bpu_pkg::*;
(
  input  ctr_t ctr_in,
  input  logic taken,
  output ctr_t ctr_out
);

  assign ctr_out = ctr_next(ctr_in, taken);

endmodule

// File: rtl/branch_predictor.sv
// IF-stage branch predictor: direct-mapped BTB with per-entry 2-bit counters, trained from EX.
// Optional BRANCH_PREDICTOR_PERF_EN adds branch / mispredict event counters.
module branch_predictor
  import bpu_pkg::*;
#(
  parameter int          ENTRIES  = 64,
  parameter int          TAG_W    = 10,
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        global_en,
  input  logic [31:0] pc_if,
  output logic        pred_taken_if,
  output logic [31:0] pred_target_if,
  input  logic        upd_valid_ex,
  input  logic [31:0] upd_pc_ex,
  input  logic        upd_is_br_ex,
  input  logic        upd_taken_ex,
  input  logic [31:0] upd_target_ex,
  input  logic        upd_pred_taken_ex,
  input  logic [31:0] upd_pred_target_ex,
`ifdef BRANCH_PREDICTOR_PERF_EN
  output logic [31:0] perf_br_cnt,
  output logic [31:0] perf_miss_cnt,
`endif
  output logic        mispredict_ex,
  output logic [31:0] redirect_pc_ex
);

  localparam int IDX_W = $clog2(ENTRIES);

  // Catch bad configurations at elaboration; the fetch PC must be word aligned.
  if ((ENTRIES < 4) || ((ENTRIES & (ENTRIES - 1)) != 0) ||
      (IDX_W + 2 + TAG_W > 32) || (RESET_PC[1:0] != 2'b00)) begin : g_bad_cfg
    $error("branch_predictor: illegal parameter set");
  end

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [29:0]        tgt_q [ENTRIES];
  ctr_t               ctr_q [ENTRIES];

  // Lookup
  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;

  assign if_idx         = pc_if[IDX_W+1:2];
  assign if_tag         = pc_if[IDX_W+2 +: TAG_W];
  assign if_hit         = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken_if  = if_hit && ctr_q[if_idx][1];
  assign pred_target_if = pred_taken_if ? {tgt_q[if_idx], 2'b00} : pc_if + 32'd4;

  // Resolution check
  assign mispredict_ex  = upd_valid_ex &&
                          ((upd_taken_ex != upd_pred_taken_ex) ||
                           (upd_taken_ex && (upd_target_ex != upd_pred_target_ex)));
  assign redirect_pc_ex = upd_taken_ex ? upd_target_ex : upd_pc_ex + 32'd4;

  // Training
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit, upd_en, alloc, train, evict, tgt_we;
  ctr_t             ctr_upd;

  assign upd_idx = upd_pc_ex[IDX_W+1:2];
  assign upd_tag = upd_pc_ex[IDX_W+2 +: TAG_W];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_en  = global_en && upd_valid_ex;
  assign alloc   = upd_en && upd_is_br_ex && !upd_hit && upd_taken_ex;
  assign train   = upd_en && upd_is_br_ex && upd_hit;
  // A non-branch that hits means the entry belongs to an aliasing PC; drop it.
  assign evict   = upd_en && !upd_is_br_ex && upd_hit;
  assign tgt_we  = alloc || (train && upd_taken_ex);

  bpu_sat_ctr u_sat_ctr (
    .ctr_in  (ctr_q[upd_idx]),
    .taken   (upd_taken_ex),
    .ctr_out (ctr_upd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_WNT;
    end else if (alloc) begin
      valid_q[upd_idx] <= 1'b1;
      ctr_q[upd_idx]   <= CTR_WT;
    end else if (train) begin
      ctr_q[upd_idx]   <= ctr_upd;
    end else if (evict) begin
      valid_q[upd_idx] <= 1'b0;
    end
  end

  // Tags and targets are never reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (alloc)  tag_q[upd_idx] <= upd_tag;
      if (tgt_we) tgt_q[upd_idx] <= upd_target_ex[31:2];
    end
  end

`ifdef BRANCH_PREDICTOR_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_br_cnt   <= '0;
      perf_miss_cnt <= '0;
    end else if (global_en) begin
      if (upd_valid_ex && upd_is_br_ex) perf_br_cnt   <= perf_br_cnt + 32'd1;
      if (mispredict_ex)                perf_miss_cnt <= perf_miss_cnt + 32'd1;
    end
  end
`endif

endmodule
